trigger_bank_sequencer: RTL

//   Command-driven controller for a bank of WIDTH JK triggers held inside the block.

---
 rtl/trigger_bank_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/trigger_bank_sequencer.sv
// Command-driven sequencer for a bank of WIDTH JK triggers (load/set/clear/toggle/count/shift).
// Optional COUNT_DOWN for opcode 111 is enabled by defining TRIG_SEQ_COUNT_DOWN_EN.
module trigger_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Cmd_valid,
  output logic             Cmd_ready,
  input  logic [2:0]       Cmd_op,
  input  logic [WIDTH-1:0] Cmd_arg,
  input  logic [CNT_W-1:0] Cmd_len,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OP_NOP        = 3'b000;
  localparam logic [2:0] OP_LOAD       = 3'b001;
  localparam logic [2:0] OP_CLEAR      = 3'b010;
  localparam logic [2:0] OP_SET        = 3'b011;
  localparam logic [2:0] OP_TOGGLE     = 3'b100;
  localparam logic [2:0] OP_COUNT_UP   = 3'b101;
  localparam logic [2:0] OP_SHIFT_L    = 3'b110;
  localparam logic [2:0] OP_COUNT_DOWN = 3'b111;

`ifdef TRIG_SEQ_COUNT_DOWN_EN
  localparam logic COUNT_DOWN_EN = 1'b1;
`else
  localparam logic COUNT_DOWN_EN = 1'b0;
`endif

  state_t             state_reg, state_next;
  logic [2:0]         op_reg, op_next;
  logic [WIDTH-1:0]   arg_reg, arg_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [WIDTH-1:0]   q_reg, q_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;

  logic [WIDTH-1:0]   j_drive, k_drive;
  logic [WIDTH-1:0]   up_tgl, down_tgl, shift_nxt;
  logic               cmd_multi;

  // Count toggle masks: a bit flips when all lower bits are 1 (up) or all 0 (down)
  assign up_tgl[0]   = 1'b1;
  assign down_tgl[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_tgl
      assign up_tgl[gi]   = &q_reg[gi-1:0];
      assign down_tgl[gi] = ~|q_reg[gi-1:0];
    end
  endgenerate

  assign shift_nxt = {q_reg[WIDTH-2:0], arg_reg[0]};

  assign cmd_multi = (Cmd_op == OP_COUNT_UP) || (Cmd_op == OP_SHIFT_L) ||
                     (COUNT_DOWN_EN && (Cmd_op == OP_COUNT_DOWN));

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    arg_next   = arg_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    j_drive    = '0;
    k_drive    = '0;
    case (state_reg)
      ST_IDLE: begin
        if (Cmd_valid) begin
          op_next  = Cmd_op;
          arg_next = Cmd_arg;
          if (!cmd_multi) begin
            count_next = CNT_W'(1);
            state_next = ST_RUN;
          end else if (Cmd_len == '0) begin
            // Zero-length multi-cycle op completes without entering RUN
            count_next = '0;
            done_next  = 1'b1;
          end else begin
            count_next = Cmd_len;
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        case (op_reg)
          OP_LOAD:     begin j_drive = arg_reg;   k_drive = ~arg_reg;   end
          OP_CLEAR:    begin j_drive = '0;        k_drive = arg_reg;    end
          OP_SET:      begin j_drive = arg_reg;   k_drive = '0;         end
          OP_TOGGLE:   begin j_drive = arg_reg;   k_drive = arg_reg;    end
          OP_COUNT_UP: begin j_drive = up_tgl;    k_drive = up_tgl;     end
          OP_SHIFT_L:  begin j_drive = shift_nxt; k_drive = ~shift_nxt; end
`ifdef TRIG_SEQ_COUNT_DOWN_EN
          OP_COUNT_DOWN: begin j_drive = down_tgl; k_drive = down_tgl; end
`endif
          default:     begin j_drive = '0;        k_drive = '0;         end
        endcase
        count_next = count_reg - CNT_W'(1);
        if (count_reg <= CNT_W'(1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
`ifndef TRIG_SEQ_COUNT_DOWN_EN
          err_next   = (op_reg == OP_COUNT_DOWN);
`endif
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-bit JK trigger: 00 hold, 01 reset, 10 set, 11 toggle
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
      assign q_next[gi] = (j_drive[gi] && k_drive[gi]) ? ~q_reg[gi] :
                          j_drive[gi]                  ? 1'b1       :
                          k_drive[gi]                  ? 1'b0       : q_reg[gi];
    end
  endgenerate

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= ST_IDLE;
      op_reg    <= OP_NOP;
      arg_reg   <= '0;
      count_reg <= '0;
      q_reg     <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      arg_reg   <= arg_next;
      count_reg <= count_next;
      q_reg     <= q_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign J         = j_drive;
  assign K         = k_drive;
  assign Q         = q_reg;
  assign Busy      = (state_reg == ST_RUN);
  assign Cmd_ready = (state_reg == ST_IDLE);
  assign Done      = done_reg;
  assign Err       = err_reg;

endmodule
